// File: rtl/gcd_disp_pkg.sv
// Shared types and constants for the gcd result display: FSM states,
// seven-segment glyphs (active-high form) and the double-dabble adjust step.
package gcd_disp_pkg;

    localparam int unsigned BCD_W = 8;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned SEG_W = 8;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPDATE
    } state_t;

    // Glyph bit order is {dp,g,f,e,d,c,b,a}; dp is never lit.
    localparam logic [SEG_W-1:0] SEG_0     = 8'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 8'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 8'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 8'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 8'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 8'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 8'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 8'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 8'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 8'h6F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

    function automatic logic [NIB_W-1:0] dd_adjust(input logic [NIB_W-1:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/seven_seg_encoder.sv
// Combinational BCD nibble to seven-segment glyph, with blanking and
// selectable output polarity.
module seven_seg_encoder
    import gcd_disp_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    input  logic             blank,
    input  logic             active_low,
    output logic [SEG_W-1:0] seg_c
);

    logic [SEG_W-1:0] glyph;

    always_comb begin
        glyph = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'd0:    glyph = SEG_0;
                4'd1:    glyph = SEG_1;
                4'd2:    glyph = SEG_2;
                4'd3:    glyph = SEG_3;
                4'd4:    glyph = SEG_4;
                4'd5:    glyph = SEG_5;
                4'd6:    glyph = SEG_6;
                4'd7:    glyph = SEG_7;
                4'd8:    glyph = SEG_8;
                4'd9:    glyph = SEG_9;
                default: glyph = SEG_BLANK;
            endcase
        end
        seg_c = active_low ? ~glyph : glyph;
    end

endmodule

// File: rtl/gcd_result_display.sv
// Captures the gcd result on each rising done, converts it to BCD one bit per
// cycle (shift-and-add-3) and drives two registered seven-segment digits.
module gcd_result_display
    import gcd_disp_pkg::*;
#(
    parameter int unsigned WIDTH          = 5,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          BLANK_LEAD     = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             done,
    input  logic [WIDTH-1:0] result,
    output logic [SEG_W-1:0] disp0,
    output logic [SEG_W-1:0] disp1,
    output logic [BCD_W-1:0] bcd,
    output logic             busy,
    output logic             valid
);

    localparam int unsigned SR_W = BCD_W + WIDTH;
    localparam logic [SEG_W-1:0] RST_DISP0 = SEG_ACTIVE_LOW ? ~SEG_0 : SEG_0;
    localparam logic [SEG_W-1:0] RST_BLANK = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
    localparam logic [SEG_W-1:0] RST_DISP1 = BLANK_LEAD ? RST_BLANK : RST_DISP0;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state, state_n;
    logic [SR_W-1:0]    sr, sr_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               pending, pending_n;
    logic [WIDTH-1:0]   pending_val, pending_val_n;
    logic               done_q;
    logic [BCD_W-1:0]   bcd_n;
    logic [SEG_W-1:0]   disp0_n, disp1_n;
    logic               busy_n, valid_n;

    logic               rise_c;
    logic [NIB_W-1:0]   tens_c, ones_c;
    logic [SR_W-1:0]    sr_adj_c, sr_shift_c;
    logic [SEG_W-1:0]   seg0_c, seg1_c;

    assign rise_c = done & ~done_q;
    assign tens_c = sr[SR_W-1 -: NIB_W];
    assign ones_c = sr[SR_W-1-NIB_W -: NIB_W];

    // One double-dabble iteration: adjust both BCD nibbles, then shift left.
    always_comb begin
        sr_adj_c                     = sr;
        sr_adj_c[WIDTH +: NIB_W]         = dd_adjust(sr[WIDTH +: NIB_W]);
        sr_adj_c[WIDTH+NIB_W +: NIB_W]   = dd_adjust(sr[WIDTH+NIB_W +: NIB_W]);
        sr_shift_c                   = sr_adj_c << 1;
    end

    seven_seg_encoder u_enc0 (
        .nibble     (ones_c),
        .blank      (1'b0),
        .active_low (SEG_ACTIVE_LOW),
        .seg_c      (seg0_c)
    );

    seven_seg_encoder u_enc1 (
        .nibble     (tens_c),
        .blank      (BLANK_LEAD && (tens_c == 4'd0)),
        .active_low (SEG_ACTIVE_LOW),
        .seg_c      (seg1_c)
    );

    always_comb begin
        state_n       = state;
        sr_n          = sr;
        cnt_n         = cnt;
        pending_n     = pending;
        pending_val_n = pending_val;
        bcd_n         = bcd;
        disp0_n       = disp0;
        disp1_n       = disp1;
        busy_n        = busy;
        valid_n       = done ? valid : 1'b0;

        case (state)
            IDLE: begin
                if (rise_c) begin
                    sr_n    = {{BCD_W{1'b0}}, result};
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (rise_c) begin
                    pending_n     = 1'b1;
                    pending_val_n = result;
                end
                sr_n = sr_shift_c;
                if (cnt == LAST_ITER) begin
                    state_n = UPDATE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            UPDATE: begin
                bcd_n   = {tens_c, ones_c};
                disp0_n = seg0_c;
                disp1_n = seg1_c;
                valid_n = done;
                // A rise landing on this edge is newer than any queued value.
                if (pending || rise_c) begin
                    sr_n      = {{BCD_W{1'b0}}, (rise_c ? result : pending_val)};
                    cnt_n     = '0;
                    pending_n = 1'b0;
                    state_n   = SHIFT;
                end else begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sr          <= '0;
            cnt         <= '0;
            pending     <= 1'b0;
            pending_val <= '0;
            done_q      <= 1'b0;
            bcd         <= '0;
            disp0       <= RST_DISP0;
            disp1       <= RST_DISP1;
            busy        <= 1'b0;
            valid       <= 1'b0;
        end else begin
            state       <= state_n;
            sr          <= sr_n;
            cnt         <= cnt_n;
            pending     <= pending_n;
            pending_val <= pending_val_n;
            done_q      <= done;
            bcd         <= bcd_n;
            disp0       <= disp0_n;
            disp1       <= disp1_n;
            busy        <= busy_n;
            valid       <= valid_n;
        end
    end

endmodule
